// File: rtl/alu_sequencer_if.sv
// Handshake and datapath bundle between the instruction sequencer, the
// relay ALU and alu_sequencer; the sequencer side is 'slave'.
interface alu_sequencer_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [2:0]       func;
  logic             dest;
  logic             cmp;
  logic [WIDTH-1:0] result_in;
  logic             carry_in;
  logic             zero_in;

  logic [2:0]       alu_func;
  logic             load_a;
  logic             load_d;
  logic             busy;
  logic             done;
  logic             err;
  logic             flag_z;
  logic             flag_c;
  logic             flag_s;

  modport master (
    output start, func, dest, cmp, result_in, carry_in, zero_in,
    input  alu_func, load_a, load_d, busy, done, err, flag_z, flag_c, flag_s
  );

  modport slave (
    input  start, func, dest, cmp, result_in, carry_in, zero_in,
    output alu_func, load_a, load_d, busy, done, err, flag_z, flag_c, flag_s
  );
endinterface

// File: rtl/alu_sequencer.sv
// Multi-cycle relay-ALU controller: DRIVE -> SETTLE -> LATCH -> DONE.
// Optional feature: define ALU_SEQ_CMP_EN for compare-only (no writeback) operations.
module alu_sequencer #(
  parameter int WIDTH         = 8,
  parameter int SETTLE_CYCLES = 8
) (
  input logic            clk,
  input logic            reset_n,
  alu_sequencer_if.slave bus
);

  localparam int SETTLE_EFF = (SETTLE_CYCLES < 1) ? 1 : SETTLE_CYCLES;
  localparam int CNT_W      = (SETTLE_CYCLES < 1) ? 1 : $clog2(SETTLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(SETTLE_EFF - 1);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_DRIVE  = 3'd1;
  localparam logic [2:0] ST_SETTLE = 3'd2;
  localparam logic [2:0] ST_LATCH  = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  localparam logic [2:0] F_ADD = 3'd0;
  localparam logic [2:0] F_INC = 3'd1;
  localparam logic [2:0] F_SHL = 3'd6;

  // Only the arithmetic-style functions produce a meaningful relay carry.
  function automatic logic keeps_carry(input logic [2:0] f);
    return (f == F_ADD) || (f == F_INC) || (f == F_SHL);
  endfunction

  logic [2:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_dest;
  logic [2:0]       r_alu_func;
  logic             r_load_a;
  logic             r_load_d;
  logic             r_busy;
  logic             r_done;
  logic             r_err;
  logic             r_flag_z;
  logic             r_flag_c;
  logic             r_flag_s;

  logic [2:0]       w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_accept;
  logic             w_wb_en;

  always_comb begin
    w_accept    = ((r_state == ST_IDLE) || (r_state == ST_DONE)) && bus.start;
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE:   if (bus.start) w_state_nxt = ST_DRIVE;
      ST_DRIVE: begin
        w_state_nxt = ST_SETTLE;
        w_cnt_nxt   = CNT_INIT;
      end
      ST_SETTLE: begin
        if (r_cnt == '0) w_state_nxt = ST_LATCH;
        else             w_cnt_nxt   = r_cnt - 1'b1;
      end
      ST_LATCH:  w_state_nxt = ST_DONE;
      ST_DONE:   w_state_nxt = bus.start ? ST_DRIVE : ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

`ifdef ALU_SEQ_CMP_EN
  logic r_cmp;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)      r_cmp <= 1'b0;
    else if (w_accept) r_cmp <= bus.cmp;
  end

  assign w_wb_en = ~r_cmp;
`else
  assign w_wb_en = 1'b1;
`endif

  // Every output is decoded from the next state so all of them leave a flop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_dest     <= 1'b0;
      r_alu_func <= 3'd0;
      r_load_a   <= 1'b0;
      r_load_d   <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_flag_z   <= 1'b0;
      r_flag_c   <= 1'b0;
      r_flag_s   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_busy   <= (w_state_nxt == ST_DRIVE) || (w_state_nxt == ST_SETTLE) ||
                  (w_state_nxt == ST_LATCH);
      r_done   <= (w_state_nxt == ST_DONE);
      r_err    <= r_busy && bus.start;
      r_load_a <= (w_state_nxt == ST_LATCH) && (r_state == ST_SETTLE) && w_wb_en && !r_dest;
      r_load_d <= (w_state_nxt == ST_LATCH) && (r_state == ST_SETTLE) && w_wb_en &&  r_dest;

      if (w_accept) begin
        r_dest     <= bus.dest;
        r_alu_func <= bus.func;
      end else if ((w_state_nxt == ST_IDLE) || (w_state_nxt == ST_DONE)) begin
        r_alu_func <= 3'd0;
      end

      // The relay chain has resolved by the end of LATCH; flags hold until the next one.
      if (r_state == ST_LATCH) begin
        r_flag_z <= bus.zero_in;
        r_flag_s <= bus.result_in[WIDTH-1];
        r_flag_c <= keeps_carry(r_alu_func) ? bus.carry_in : 1'b0;
      end
    end
  end

  assign bus.alu_func = r_alu_func;
  assign bus.load_a   = r_load_a;
  assign bus.load_d   = r_load_d;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.err      = r_err;
  assign bus.flag_z   = r_flag_z;
  assign bus.flag_c   = r_flag_c;
  assign bus.flag_s   = r_flag_s;

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard testbench for alu_sequencer (SETTLE_CYCLES = 8).
`timescale 1ns/1ps
module tb_alu_sequencer;

  localparam int WIDTH      = 8;
  localparam int SETTLE     = 8;
  // Edge counts after the accepting edge: LATCH starts S+1 edges later, DONE S+2.
  localparam int LAT_LOAD   = SETTLE + 1;
  localparam int LAT_DONE   = SETTLE + 2;
  localparam int PERIOD_OPS = SETTLE + 3;
`ifdef ALU_SEQ_CMP_EN
  localparam bit CMP_EN = 1'b1;
`else
  localparam bit CMP_EN = 1'b0;
`endif

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  int   cyc     = 0;
  int   errors  = 0;
  int   checks  = 0;

  alu_sequencer_if #(.WIDTH(WIDTH)) bus ();

  alu_sequencer #(.WIDTH(WIDTH), .SETTLE_CYCLES(SETTLE)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [2:0] func;
    logic       la;
    logic       ld;
    logic       z;
    logic       c;
    logic       s;
  } exp_t;

  typedef struct {
    bit         timeout;
    int         done_cyc;
    int         load_cyc;
    int         na;
    int         nd;
    int         gaps;
    int         nerr;
    logic [2:0] func_done;
    logic       z;
    logic       c;
    logic       s;
  } obs_t;

  exp_t sb[$];

  function automatic exp_t model(input logic [2:0] f, input logic d, input logic cm,
                                 input logic [WIDTH-1:0] r, input logic c, input logic z);
    exp_t e;
    logic wb;
    wb     = !(CMP_EN && cm);
    e.func = f;
    e.la   = wb && !d;
    e.ld   = wb && d;
    e.z    = z;
    e.s    = r[WIDTH-1];
    e.c    = (f == 3'd0 || f == 3'd1 || f == 3'd6) ? c : 1'b0;
    return e;
  endfunction

  task automatic set_inputs(input logic [2:0] f, input logic d, input logic cm,
                            input logic [WIDTH-1:0] r, input logic c, input logic z);
    bus.func      = f;
    bus.dest      = d;
    bus.cmp       = cm;
    bus.result_in = r;
    bus.carry_in  = c;
    bus.zero_in   = z;
  endtask

  task automatic issue(output int t_acc, output logic [2:0] drv_func, output logic drv_busy);
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1 t_acc = cyc;
    @(negedge clk);
    drv_func  = bus.alu_func;
    drv_busy  = bus.busy;
    bus.start = 1'b0;
  endtask

  task automatic observe(output obs_t o);
    o = '{timeout: 1'b0, done_cyc: -1, load_cyc: -1, na: 0, nd: 0, gaps: 0, nerr: 0,
          func_done: 3'd0, z: 1'b0, c: 1'b0, s: 1'b0};
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bus.load_a) begin o.na++; o.load_cyc = cyc; end
      if (bus.load_d) begin o.nd++; o.load_cyc = cyc; end
      if (bus.err) o.nerr++;
      if (bus.done) begin
        o.done_cyc  = cyc;
        o.func_done = bus.alu_func;
        o.z = bus.flag_z; o.c = bus.flag_c; o.s = bus.flag_s;
        return;
      end
      if (!bus.busy) o.gaps++;
    end
    o.timeout = 1'b1;
  endtask

  task automatic test_reset();
    logic [10:0] outs;
    int rises;
    bus.start = 1'b0;
    set_inputs(3'd0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    reset_n = 1'b0;
    #1;
    outs = {bus.alu_func, bus.load_a, bus.load_d, bus.busy, bus.done, bus.err,
            bus.flag_z, bus.flag_c, bus.flag_s};
    checks++;
    if (outs !== 11'd0) begin
      errors++; $display("FAIL reset_async outs=%b expected=%b", outs, 11'd0);
    end
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    rises = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.busy !== 1'b0) rises++;
    end
    checks++;
    if (rises !== 0) begin
      errors++; $display("FAIL idle_busy busy_cycles=%0d expected=0", rises);
    end
    outs = {bus.alu_func, bus.load_a, bus.load_d, bus.busy, bus.done, bus.err,
            bus.flag_z, bus.flag_c, bus.flag_s};
    checks++;
    if (outs !== 11'd0) begin
      errors++; $display("FAIL idle_outs outs=%b expected=%b", outs, 11'd0);
    end
  endtask

  task automatic test_add();
    int t; logic [2:0] df; logic db; obs_t o; exp_t e;
    set_inputs(3'd0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    sb.push_back(model(3'd0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1));
    issue(t, df, db);
    checks++;
    if (db !== 1'b1) begin errors++; $display("FAIL add_busy got=%b expected=1", db); end
    observe(o);
    e = sb.pop_front();
    checks++;
    if (o.timeout) begin errors++; $display("FAIL add_timeout got=timeout expected=done"); end
    checks++;
    if (o.done_cyc - t !== LAT_DONE) begin
      errors++; $display("FAIL add_done_lat got=%0d expected=%0d", o.done_cyc - t, LAT_DONE);
    end
    checks++;
    if (o.load_cyc - t !== LAT_LOAD) begin
      errors++; $display("FAIL add_load_lat got=%0d expected=%0d", o.load_cyc - t, LAT_LOAD);
    end
    checks++;
    if (o.na !== 1 || o.nd !== 0) begin
      errors++; $display("FAIL add_strobes got a=%0d d=%0d expected a=1 d=0", o.na, o.nd);
    end
    checks++;
    if ({o.z, o.c, o.s} !== {e.z, e.c, e.s}) begin
      errors++; $display("FAIL add_flags got=%b expected=%b", {o.z, o.c, o.s}, {e.z, e.c, e.s});
    end
    checks++;
    if (o.gaps !== 0 || o.nerr !== 0 || o.func_done !== 3'd0) begin
      errors++; $display("FAIL add_misc got gaps=%0d err=%0d func=%0d expected 0/0/0",
                         o.gaps, o.nerr, o.func_done);
    end
    @(negedge clk);
    checks++;
    if ({bus.flag_z, bus.flag_c, bus.flag_s} !== {e.z, e.c, e.s}) begin
      errors++; $display("FAIL add_flag_hold got=%b expected=%b",
                         {bus.flag_z, bus.flag_c, bus.flag_s}, {e.z, e.c, e.s});
    end
  endtask

  task automatic test_xor_d();
    int t; logic [2:0] df; logic db; obs_t o; exp_t e;
    set_inputs(3'd4, 1'b1, 1'b0, 8'h80, 1'b1, 1'b0);
    sb.push_back(model(3'd4, 1'b1, 1'b0, 8'h80, 1'b1, 1'b0));
    issue(t, df, db);
    checks++;
    if (df !== 3'd4) begin errors++; $display("FAIL xor_alu_func got=%0d expected=4", df); end
    observe(o);
    e = sb.pop_front();
    checks++;
    if (o.timeout || o.done_cyc - t !== LAT_DONE) begin
      errors++; $display("FAIL xor_done_lat got=%0d expected=%0d", o.done_cyc - t, LAT_DONE);
    end
    checks++;
    if (o.na !== 0 || o.nd !== 1 || o.load_cyc - t !== LAT_LOAD) begin
      errors++; $display("FAIL xor_strobes got a=%0d d=%0d at=%0d expected a=0 d=1 at=%0d",
                         o.na, o.nd, o.load_cyc - t, LAT_LOAD);
    end
    checks++;
    if ({o.z, o.c, o.s} !== {e.z, e.c, e.s}) begin
      errors++; $display("FAIL xor_flags got=%b expected=%b", {o.z, o.c, o.s}, {e.z, e.c, e.s});
    end
  endtask

  task automatic test_func_table();
    logic [2:0] tf[6]; logic td[6]; logic [7:0] tr[6]; logic tc[6]; logic tz[6];
    int t; logic [2:0] df; logic db; obs_t o; exp_t e;
    tf = '{3'd5, 3'd6, 3'd1, 3'd7, 3'd2, 3'd3};
    td = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    tr = '{8'h0F, 8'hA0, 8'h00, 8'h00, 8'hFF, 8'h81};
    tc = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    tz = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 6; i++) begin
      set_inputs(tf[i], td[i], 1'b0, tr[i], tc[i], tz[i]);
      sb.push_back(model(tf[i], td[i], 1'b0, tr[i], tc[i], tz[i]));
      issue(t, df, db);
      checks++;
      if (df !== tf[i]) begin
        errors++; $display("FAIL tbl%0d_alu_func got=%0d expected=%0d", i, df, tf[i]);
      end
      observe(o);
      e = sb.pop_front();
      checks++;
      if (o.timeout || o.done_cyc - t !== LAT_DONE) begin
        errors++; $display("FAIL tbl%0d_done_lat got=%0d expected=%0d", i, o.done_cyc - t, LAT_DONE);
      end
      checks++;
      if (o.na !== int'(e.la) || o.nd !== int'(e.ld)) begin
        errors++; $display("FAIL tbl%0d_strobes got a=%0d d=%0d expected a=%0d d=%0d",
                           i, o.na, o.nd, e.la, e.ld);
      end
      checks++;
      if ({o.z, o.c, o.s} !== {e.z, e.c, e.s}) begin
        errors++; $display("FAIL tbl%0d_flags got=%b expected=%b", i, {o.z, o.c, o.s}, {e.z, e.c, e.s});
      end
    end
  endtask

  task automatic test_collision();
    int t; logic [2:0] df; logic db; obs_t o; exp_t e; int extra;
    set_inputs(3'd0, 1'b0, 1'b0, 8'h7F, 1'b1, 1'b0);
    sb.push_back(model(3'd0, 1'b0, 1'b0, 8'h7F, 1'b1, 1'b0));
    issue(t, df, db);
    repeat (3) @(negedge clk);
    bus.start = 1'b1;
    bus.func  = 3'd7;
    bus.dest  = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.err !== 1'b1) begin
      errors++; $display("FAIL col_err got=%b expected=1 (cycle offset %0d)", bus.err, cyc - t);
    end
    bus.start = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.err !== 1'b0) begin errors++; $display("FAIL col_err_pulse got=%b expected=0", bus.err); end
    observe(o);
    e = sb.pop_front();
    checks++;
    if (o.timeout || o.done_cyc - t !== LAT_DONE) begin
      errors++; $display("FAIL col_done_lat got=%0d expected=%0d", o.done_cyc - t, LAT_DONE);
    end
    checks++;
    if (o.na !== 1 || o.nd !== 0) begin
      errors++; $display("FAIL col_strobes got a=%0d d=%0d expected a=1 d=0", o.na, o.nd);
    end
    checks++;
    if ({o.z, o.c, o.s} !== {e.z, e.c, e.s}) begin
      errors++; $display("FAIL col_flags got=%b expected=%b", {o.z, o.c, o.s}, {e.z, e.c, e.s});
    end
    extra = 0;
    repeat (PERIOD_OPS + 2) begin
      @(negedge clk);
      if (bus.busy || bus.done || bus.load_a || bus.load_d) extra++;
    end
    checks++;
    if (extra !== 0) begin errors++; $display("FAIL col_no_second got=%0d active cycles expected=0", extra); end
  endtask

  task automatic test_back_to_back();
    logic [2:0] bf[3]; logic bd[3]; logic [7:0] br[3]; logic bc[3]; logic bz[3];
    int t0; obs_t o; exp_t e;
    bf = '{3'd1, 3'd6, 3'd2};
    bd = '{1'b0, 1'b1, 1'b0};
    br = '{8'h01, 8'hFE, 8'h00};
    bc = '{1'b0, 1'b1, 1'b1};
    bz = '{1'b0, 1'b0, 1'b1};
    set_inputs(bf[0], bd[0], 1'b0, br[0], bc[0], bz[0]);
    sb.push_back(model(bf[0], bd[0], 1'b0, br[0], bc[0], bz[0]));
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1 t0 = cyc;
    for (int k = 0; k < 3; k++) begin
      observe(o);
      if (k < 2) begin
        set_inputs(bf[k+1], bd[k+1], 1'b0, br[k+1], bc[k+1], bz[k+1]);
        sb.push_back(model(bf[k+1], bd[k+1], 1'b0, br[k+1], bc[k+1], bz[k+1]));
      end else begin
        bus.start = 1'b0;
      end
      e = sb.pop_front();
      checks++;
      if (o.timeout || o.done_cyc - t0 !== LAT_DONE + k * PERIOD_OPS) begin
        errors++; $display("FAIL b2b%0d_done_at got=%0d expected=%0d", k, o.done_cyc - t0,
                           LAT_DONE + k * PERIOD_OPS);
      end
      checks++;
      if (o.na !== int'(e.la) || o.nd !== int'(e.ld) || o.gaps !== 0) begin
        errors++; $display("FAIL b2b%0d_strobes got a=%0d d=%0d gaps=%0d expected a=%0d d=%0d gaps=0",
                           k, o.na, o.nd, o.gaps, e.la, e.ld);
      end
      checks++;
      if ({o.z, o.c, o.s} !== {e.z, e.c, e.s}) begin
        errors++; $display("FAIL b2b%0d_flags got=%b expected=%b", k, {o.z, o.c, o.s}, {e.z, e.c, e.s});
      end
    end
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++; $display("FAIL b2b_stop got busy=%b done=%b expected 0/0", bus.busy, bus.done);
    end
  endtask

  task automatic test_abort();
    int t; logic [2:0] df; logic db; logic [10:0] outs; int act;
    set_inputs(3'd0, 1'b1, 1'b0, 8'h80, 1'b1, 1'b1);
    issue(t, df, db);
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    #1;
    outs = {bus.alu_func, bus.load_a, bus.load_d, bus.busy, bus.done, bus.err,
            bus.flag_z, bus.flag_c, bus.flag_s};
    checks++;
    if (outs !== 11'd0) begin errors++; $display("FAIL abort_outs got=%b expected=%b", outs, 11'd0); end
    @(negedge clk);
    reset_n = 1'b1;
    act = 0;
    repeat (PERIOD_OPS + 4) begin
      @(negedge clk);
      if (bus.load_a || bus.load_d || bus.done || bus.busy) act++;
    end
    checks++;
    if (act !== 0) begin errors++; $display("FAIL abort_quiet got=%0d active cycles expected=0", act); end
    checks++;
    if ({bus.flag_z, bus.flag_c, bus.flag_s} !== 3'b000) begin
      errors++; $display("FAIL abort_flags got=%b expected=000", {bus.flag_z, bus.flag_c, bus.flag_s});
    end
  endtask

  task automatic test_compare();
    int t; logic [2:0] df; logic db; obs_t o; exp_t e;
    set_inputs(3'd3, 1'b0, 1'b1, 8'h80, 1'b1, 1'b0);
    sb.push_back(model(3'd3, 1'b0, 1'b1, 8'h80, 1'b1, 1'b0));
    issue(t, df, db);
    observe(o);
    e = sb.pop_front();
    bus.cmp = 1'b0;
    checks++;
    if (o.timeout || o.done_cyc - t !== LAT_DONE) begin
      errors++; $display("FAIL cmp_done_lat got=%0d expected=%0d", o.done_cyc - t, LAT_DONE);
    end
    checks++;
    if (o.na !== int'(e.la) || o.nd !== int'(e.ld)) begin
      errors++; $display("FAIL cmp_strobes got a=%0d d=%0d expected a=%0d d=%0d", o.na, o.nd, e.la, e.ld);
    end
    checks++;
    if ({o.z, o.c, o.s} !== {e.z, e.c, e.s}) begin
      errors++; $display("FAIL cmp_flags got=%b expected=%b", {o.z, o.c, o.s}, {e.z, e.c, e.s});
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_xor_d();
    test_func_table();
    test_collision();
    test_back_to_back();
    test_abort();
    test_compare();
    checks++;
    if (sb.size() !== 0) begin errors++; $display("FAIL sb_drain got=%0d left expected=0", sb.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Multi-cycle controller that drives the relay ALU and its zero-detect chain. On each `start` it presents a function code to the ALU and waits a fixed settle time so the slow relay ripple, including the 8-relay zero-detect chain, can resolve. It then pulses a register load strobe, captures the Z/C/S condition flags and signals completion. It sits between the instruction sequencer and the ALU/register file and is the only agent that drives the ALU function select.

## Interface
Parameters:
- `WIDTH`, 8, datapath width of the ALU result.
- `SETTLE_CYCLES`, 8, number of cycles spent in SETTLE; a value of 0 behaves as 1.

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request one ALU operation; sampled when `busy` is 0.
- `func`  in  3  operation, captured on accept: 0 ADD, 1 INC, 2 AND, 3 OR, 4 XOR, 5 NOT, 6 SHL, 7 CLR.
- `dest`  in  1  destination, captured on accept: 0 = A, 1 = D.
- `cmp`  in  1  compare-only request; see Configuration.
- `result_in`  in  WIDTH  ALU result.
- `carry_in`  in  1  ALU carry out.
- `zero_in`  in  1  zero-detect chain output.
- `alu_func`  out  3  function select to ALU.
- `load_a`, `load_d`  out  1 each  one-cycle register write strobes.
- `busy`  out  1  operation in progress.
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  one-cycle pulse when `start` is rejected.
- `flag_z`, `flag_c`, `flag_s`  out  1 each  condition flags, held until the next LATCH.

## Operation
States and transitions:
- IDLE: `start` = 1 captures `func`, `dest` and `cmp`, then goes to DRIVE.
- DRIVE: 1 cycle; `alu_func` is driven with the captured func. Goes to SETTLE.
- SETTLE: counter loads `SETTLE_CYCLES - 1` on entry and decrements each cycle; at 0 goes to LATCH. The counter is `$clog2(SETTLE_CYCLES+1)` bits wide and must not wrap.
- LATCH: 1 cycle. Behaviour in this cycle:
  - Samples `result_in`, `carry_in` and `zero_in`.
  - Asserts `load_a` if dest = 0, or `load_d` if dest = 1. Never both.
  - Goes to DONE.
- DONE: 1 cycle with `done` = 1. `start` = 1 here is accepted exactly as in IDLE and goes straight to DRIVE; otherwise goes to IDLE.

Outputs:
- `alu_func` holds the captured func from DRIVE through LATCH and is 0 in IDLE and DONE.
- `busy` = 1 in DRIVE, SETTLE and LATCH.

Flag rules, updated in LATCH only:
- `flag_z` = `zero_in`.
- `flag_s` = `result_in[WIDTH-1]`.
- `flag_c` = `carry_in` for ADD, INC and SHL, and 0 for every other func.

Boundary conditions:
- `start` while `busy` = 1: the request is ignored, the operation in flight is unaffected, and `err` = 1 on the next cycle.
- `reset_n` low at any time: immediately returns to IDLE with all outputs at reset values. No load strobe may be emitted for the aborted operation.

## Timing
- Reset values: state IDLE; `alu_func` = 0; `load_a`, `load_d`, `busy`, `done`, `err` = 0; all flags = 0.
- With `start` accepted at edge t:
  - DRIVE during cycle t+1.
  - SETTLE during t+2 .. t+1+SETTLE_CYCLES.
  - LATCH during t+2+SETTLE_CYCLES.
  - `done` high during t+3+SETTLE_CYCLES.
- Total latency from `start` to `done` is SETTLE_CYCLES+3 cycles. Back-to-back issue gives one operation per SETTLE_CYCLES+3 cycles.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- `result_in`, `carry_in` and `zero_in` need to be valid only in the LATCH cycle.

## Configuration
- `ALU_SEQ_CMP_EN` defined:
  - `cmp` = 1 on accept runs the full sequence and updates the flags.
  - `load_a` and `load_d` stay 0 for that operation (compare without writeback).
- `ALU_SEQ_CMP_EN` undefined:
  - `cmp` is ignored and every operation writes its destination.
  - Timing is identical either way.

## Test plan
- Reset then idle: hold `reset_n` = 0, release, wait 5 cycles -> all outputs 0, `busy` never rises.
- ADD, SETTLE_CYCLES = 8: `start` with func = 0, dest = 0, drive `result_in` = 8'h00, `carry_in` = 1, `zero_in` = 1 -> `load_a` pulses in cycle t+10 and `done` in t+11; flags Z = 1, C = 1, S = 0; `load_d` stays 0.
- XOR to D with carry noise: func = 4, dest = 1, `result_in` = 8'h80, `carry_in` = 1, `zero_in` = 0 -> `load_d` pulses; Z = 0, C = 0, S = 1.
- Collision: `start` again at t+4 during SETTLE -> `err` pulses at t+5; first operation completes at t+11 unchanged; no second operation is started.
- Back-to-back: `start` held high -> `done` pulses at t+11, t+22 and t+33; `busy` low only during DONE cycles.
- Abort and compare:
  - Assert `reset_n` = 0 in SETTLE -> no load strobe, flags 0.
  - With `ALU_SEQ_CMP_EN`, `cmp` = 1 -> flags update while `load_a` and `load_d` stay 0.
